// File: rtl/cpu_debug_pkg.sv
// Shared types and constants for the register-file debug dump path.
// Frame layout: one header byte, then REG_COUNT register snapshots.
package cpu_debug_pkg;

    localparam int         REG_COUNT   = 8;
    localparam int         REG_SEL_W   = 3;
    localparam logic [7:0] DUMP_HEADER = 8'hA5;

    // Full dump lifecycle; the UART serializer only ever visits IDLE and the bit states.
    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_e;

    // Frame-level sequencing kept by the dump controller.
    typedef enum logic [1:0] {
        FRM_IDLE,
        FRM_CAPTURE,
        FRM_SEND
    } frame_e;

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 serializer: accepts one byte per valid/ready handshake, LSB first.
// Latency: tx drops on the edge that accepts a byte; in_rdy rises in the last stop-bit cycle so bytes chain with no gap.
module uart_tx_byte
    import cpu_debug_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_vld,
    input  logic [7:0] in_dat,
    output logic       in_rdy,
    output logic       tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    state_e          state_q, state_d;
    logic [CW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            baud_last;

    assign baud_last = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign in_rdy    = (state_q == IDLE) || ((state_q == STOP_BIT) && baud_last);
    assign tx        = tx_q;

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        baud_d  = baud_last ? '0 : baud_q + CW'(1);

        case (state_q)
            IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                if (in_vld) begin
                    state_d = START_BIT;
                    shift_d = in_dat;
                    tx_d    = 1'b0;
                end
            end
            START_BIT: begin
                if (baud_last) begin
                    state_d = DATA_BITS;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            DATA_BITS: begin
                if (baud_last) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP_BIT;
                        tx_d    = 1'b1;
                    end else begin
                        // Shift so the next bit to send always sits at shift_q[0].
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            STOP_BIT: begin
                if (baud_last) begin
                    if (in_vld) begin
                        state_d = START_BIT;
                        shift_d = in_dat;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/reg_dump_uart.sv
// Snapshots the register file via its debug port, then streams HEADER + registers over UART 8N1.
// Capture takes NUM_REGS cycles after start; tx drops on the last capture edge. start is ignored while busy.
module reg_dump_uart
    import cpu_debug_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         NUM_REGS     = REG_COUNT,
    parameter int         SEL_W        = REG_SEL_W,
    parameter logic [7:0] HEADER       = DUMP_HEADER
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [SEL_W-1:0] debug_reg_select,
    input  logic [7:0]       debug_reg_value,
    output logic             tx,
    output logic             busy,
    output logic             done
);

    frame_e                     frame_q, frame_d;
    logic [SEL_W-1:0]           cap_idx_q, cap_idx_d;
    logic [3:0]                 byte_idx_q, byte_idx_d;
    logic [NUM_REGS-1:0][7:0]   snap_q, snap_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic                       byte_vld;
    logic                       byte_rdy;
    logic [7:0]                 byte_dat;

    assign debug_reg_select = cap_idx_q;
    assign busy             = busy_q;
    assign done             = done_q;

    always_comb begin
        frame_d    = frame_q;
        cap_idx_d  = cap_idx_q;
        byte_idx_d = byte_idx_q;
        snap_d     = snap_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        byte_vld   = 1'b0;
        byte_dat   = HEADER;

        case (frame_q)
            FRM_IDLE: begin
                if (start) begin
                    frame_d   = FRM_CAPTURE;
                    cap_idx_d = '0;
                    busy_d    = 1'b1;
                end
            end
            FRM_CAPTURE: begin
                snap_d[cap_idx_q] = debug_reg_value;
                if (cap_idx_q == SEL_W'(NUM_REGS - 1)) begin
                    // Header needs no snapshot data, so it launches on the final capture edge.
                    frame_d    = FRM_SEND;
                    cap_idx_d  = '0;
                    byte_idx_d = '0;
                    byte_vld   = 1'b1;
                    byte_dat   = HEADER;
                end else begin
                    cap_idx_d = cap_idx_q + SEL_W'(1);
                end
            end
            FRM_SEND: begin
                // byte_idx_q is the byte on the wire; the one offered next is snapshot[byte_idx_q].
                byte_vld = (byte_idx_q < 4'(NUM_REGS));
                byte_dat = snap_q[byte_idx_q[SEL_W-1:0]];
                if (byte_rdy) begin
                    if (byte_vld) begin
                        byte_idx_d = byte_idx_q + 4'd1;
                    end else begin
                        frame_d = FRM_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                frame_d = FRM_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_q    <= FRM_IDLE;
            cap_idx_q  <= '0;
            byte_idx_q <= '0;
            snap_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            frame_q    <= frame_d;
            cap_idx_q  <= cap_idx_d;
            byte_idx_q <= byte_idx_d;
            snap_q     <= snap_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .rst_n  (rst_n),
        .in_vld (byte_vld),
        .in_dat (byte_dat),
        .in_rdy (byte_rdy),
        .tx     (tx)
    );

endmodule
